// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding and count sizing.
// Optional signed operation is enabled with SHIFT_ADD_MULT_SIGNED_EN (see mult_datapath).
package shift_add_mult_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // The count must be able to hold WIDTH itself, not just WIDTH-1.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_datapath.sv
// Accumulator / multiplier-quotient shift datapath for the radix-2 shift-and-add multiplier.
// With SHIFT_ADD_MULT_SIGNED_EN defined, operands are loaded as magnitudes and the result is sign-corrected.
module mult_datapath
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,
    input  logic               step,
`ifdef SHIFT_ADD_MULT_SIGNED_EN
    input  logic               fix_sign,
`endif
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_next;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mq_next;
    logic [WIDTH-1:0]   a_load;
    logic [WIDTH-1:0]   b_load;
    logic [2*WIDTH-1:0] raw;

    // The carry out of the add lands in acc[WIDTH] and is shifted back down next step.
    assign sum                 = acc + (mq[0] ? {1'b0, mcand} : '0);
    assign {acc_next, mq_next} = {sum, mq} >> 1;
    assign raw                 = {acc_next[WIDTH-1:0], mq_next};

`ifdef SHIFT_ADD_MULT_SIGNED_EN
    logic sign_neg;

    // -2^(WIDTH-1) negates to itself, which is exactly its unsigned magnitude.
    assign a_load = a[WIDTH-1] ? -a : a;
    assign b_load = b[WIDTH-1] ? -b : b;
    assign result = (fix_sign && sign_neg) ? -raw : raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sign_neg <= 1'b0;
        end else if (ld) begin
            sign_neg <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign a_load = a;
    assign b_load = b;
    assign result = raw;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            mcand <= '0;
            mq    <= '0;
        end else if (ld) begin
            acc   <= '0;
            mcand <= a_load;
            mq    <= b_load;
        end else if (step) begin
            acc   <= acc_next;
            mq    <= mq_next;
        end
    end

endmodule

// File: rtl/shift_add_mult.sv
// Sequential radix-2 shift-and-add multiplier: controller FSM, step counter and product register.
// Define SHIFT_ADD_MULT_SIGNED_EN for two's-complement operands; default build is unsigned.
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = count_width(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic               ld;
    logic               step;
    logic               last;
    logic [2*WIDTH-1:0] result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (count == CW'(1)) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ld   = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_IDLE: ld = start;
            ST_CALC: begin
                step = 1'b1;
                busy = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // The final step's shifted value is captured directly, so product is ready as DONE begins.
    assign last = step && (count == CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (ld) begin
            count <= CW'(WIDTH);
        end else if (step) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            product <= '0;
        end else if (last) begin
            product <= result;
        end
    end

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .step     (step),
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        .fix_sign (last),
`endif
        .a        (a),
        .b        (b),
        .result   (result)
    );

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: stimulus pushes expected products, a monitor checks each done.
module tb_shift_add_mult;

    localparam int WIDTH = 4;
    localparam int PW    = 2 * WIDTH;

    typedef struct {
        logic [PW-1:0] p;
        int            c;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst   = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [PW-1:0]    product;

    exp_t          sb[$];
    int            checks    = 0;
    int            fails     = 0;
    int            cyc       = 0;
    int            busy_run  = 0;
    logic          prev_done = 1'b0;
    logic [PW-1:0] last_prod = '0;

    shift_add_mult #(
        .WIDTH(WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer multiplication, truncated to the product width.
    function automatic logic [PW-1:0] model_product(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int xv = int'(x);
        int yv = int'(y);
`ifdef SHIFT_ADD_MULT_SIGNED_EN
        if (x[WIDTH-1]) xv -= (1 << WIDTH);
        if (y[WIDTH-1]) yv -= (1 << WIDTH);
`endif
        return PW'(xv * yv);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_run  = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_done: got product %0d, expected no result", product);
                end else begin
                    e = sb.pop_front();
                    checkOutput("product", product, e.p);
                    checkOutput("latency", PW'(cyc - e.c), PW'(WIDTH));
                    checkOutput("busy_cycles", PW'(busy_run), PW'(WIDTH + 1));
                    checkOutput("done_pulse", PW'(prev_done), '0);
                    last_prod = e.p;
                end
            end
            if (!busy) begin
                checkOutput("idle_hold", product, last_prod);
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            fails++;
            $display("[TB] FAIL idle_timeout: got busy=1, expected busy=0 within 30 cycles");
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        waitIdle();
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.p = model_product(x, y);
        e.c = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   c0;
        int   n;

        #12;
        checkOutput("reset_busy", PW'(busy), '0);
        checkOutput("reset_done", PW'(done), '0);
        checkOutput("reset_product", product, '0);
        rst = 1'b1;

        applyStimulus(4'd13, 4'd11);
        applyStimulus(4'd15, 4'd15);
        applyStimulus(4'd0, 4'd9);
        applyStimulus(4'hD, 4'd5);
        applyStimulus(4'd8, 4'd8);
        applyStimulus(4'd8, 4'd7);

        // Start held high; a changes mid-operation; the next accept happens six edges later.
        waitIdle();
        a     = 4'd3;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0  = cyc;
        e.p = model_product(4'd3, 4'd5);
        e.c = c0;
        sb.push_back(e);
        @(negedge clk);
        @(negedge clk);
        a = 4'd7;
        while (cyc < c0 + 6) begin
            @(posedge clk);
            #1;
        end
        e.p = model_product(4'd7, 4'd5);
        e.c = cyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;

        // Asynchronous reset in the middle of a calculation discards it.
        applyStimulus(4'd9, 4'd9);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midreset_busy", PW'(busy), '0);
        checkOutput("midreset_done", PW'(done), '0);
        checkOutput("midreset_product", product, '0);
        sb.delete();
        last_prod = '0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        applyStimulus(4'd6, 4'd7);

        for (int i = 0; i < (1 << WIDTH); i++) begin
            for (int j = 0; j < (1 << WIDTH); j++) begin
                applyStimulus(WIDTH'(i), WIDTH'(j));
            end
        end

        for (int k = 0; k < 300; k++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom));
        end

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending results, expected 0", sb.size());
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
- Sequential unsigned integer multiplier using radix-2 shift-and-add. It is the inverse-operation companion to the team's restoring divider.
- Inputs: a multiplicand and a multiplier. Output: a 2*WIDTH-bit product after a fixed number of cycles.
- Start/done handshake with a controller FSM driving an accumulator/shift datapath.

Parameters:
- WIDTH, 4, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; captured on the accepted start.
- b  input  WIDTH  multiplier; captured on the accepted start.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result; holds until the next accepted start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0; done=0; product=0; internal acc, mcand, mq and count all 0.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE:
  - If start=1 at a rising edge: mcand<=a, mq<=b, acc<=0 (WIDTH+1 bits), count<=WIDTH, state<=CALC.
  - Otherwise stay in IDLE and hold the previous product.
- CALC, each edge:
  - sum = acc + (mq[0] ? {1'b0,mcand} : 0), computed in WIDTH+1 bits; the carry is kept.
  - {acc,mq} <= {sum,mq} >> 1, a logical right shift of the (2*WIDTH+1)-bit concatenation.
  - count <= count-1.
  - When count==1 at the edge: state<=DONE and product<={acc_next[WIDTH-1:0], mq_next}.
- DONE:
  - done=1 for exactly this cycle.
  - The next edge goes unconditionally to IDLE.
- Latency:
  - start accepted at edge E0; done is high in the cycle following edge E(WIDTH).
  - WIDTH+1 edges from start to done; next start can be accepted at edge E(WIDTH+2).
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor does it disturb the operands.
  - a and b only need to be valid on the accepting edge.
- product is updated only on the CALC->DONE transition. It is stable through DONE and IDLE until the next result overwrites it.
- Zero operands take the full WIDTH cycles; there is no early exit.
- Reset asserted mid-CALC: immediate return to the reset values. The partial result is discarded and product reads 0.
- Arithmetic:
  - Unsigned. Overflow is impossible: max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - The carry bit of acc never exceeds 1.

Optional Feature:
- Macro: SHIFT_ADD_MULT_SIGNED_EN.
- When defined, a and b are treated as two's complement:
  - On accept, the magnitudes |a| and |b| are loaded and sign_neg=a[MSB]^b[MSB] is registered.
  - At CALC->DONE, product is the 2*WIDTH-bit two's-complement negation of the raw result when sign_neg=1.
  - Latency is unchanged.
  - The most-negative operand -2^(WIDTH-1) is handled correctly: its magnitude is treated as an unsigned WIDTH-bit value.
- When not defined: purely unsigned; no sign logic, no extra register.

Decomposition:
- Package shift_add_mult_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - A function for the count width, clog2(WIDTH+1).
- One sub-module, mult_datapath:
  - Holds acc, mcand and mq, plus the adder and shifter.
  - Controls: ld, step, and (signed build) fix_sign.
- The top level keeps the FSM, count, busy/done and the product register.

Test Plan:
- WIDTH=4, a=13, b=11, start pulse -> done after 5 edges, product=8'd143, busy high for 5 cycles (4 CALC + 1 DONE).
- a=15, b=15 -> product=8'd225. a=0, b=9 -> product=0, full 5-edge latency.
- start held high through an op with a=3, b=5, then a changed to 7 mid-CALC -> product=15, no second operation until IDLE, back-to-back start then accepted at E6.
- rst=0 asserted for one cycle during CALC (asynchronous, off-edge) -> busy/done/product go to 0 immediately, and the next start with 6*7 -> 42.
- Random sweep of all 256 operand pairs for WIDTH=4, plus 1000 random pairs for WIDTH=8, checked against a model -> exact match, done exactly one cycle each.
- SHIFT_ADD_MULT_SIGNED_EN, WIDTH=4:
  - a=-3 (4'hD), b=5 -> product=8'hF1.
  - a=-8, b=-8 -> 8'h40.
  - a=-8, b=7 -> 8'hC8.
